// File: rtl/rtc_pkg.sv
// rtl/rtc_pkg.sv - shared types, 7-segment constants, reset time and BCD helpers for rtc_display_core
package rtc_pkg;

  typedef logic [3:0] bcd_t;

  // Active-high segments ordered {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Reset time: 00:00:00 in 24-hour mode, 12:00:00 AM in 12-hour mode
  localparam logic [7:0] RST_HH_24 = 8'h00;
  localparam logic [7:0] RST_HH_12 = 8'h12;
  localparam logic [7:0] RST_MM    = 8'h00;
  localparam logic [7:0] RST_SS    = 8'h00;
  localparam logic       RST_PM    = 1'b0;

  // True when both nibbles of a packed BCD byte are decimal digits
  function automatic logic bcd_ok(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  // Add one to a two-digit BCD value; callers handle the wrap points
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [3:0] tens;
    logic [3:0] units;
    tens  = v[7:4];
    units = v[3:0];
    if (units == 4'd9) begin
      return {tens + 4'd1, 4'd0};
    end
    return {tens, units + 4'd1};
  endfunction

endpackage

// File: rtl/seg7_encoder.sv
// rtl/seg7_encoder.sv - BCD digit to active-high 7-segment pattern
module seg7_encoder
  import rtc_pkg::*;
(
  input  bcd_t       i_bcd,
  output logic [6:0] o_seg
);

  // Lookup of the standard digit shapes; non-decimal codes go dark
  always_comb begin
    o_seg = SEG_BLANK;
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/rtc_display_core.sv
// rtl/rtc_display_core.sv - BCD real-time clock with 7-segment outputs; alarm built when RTC_ALARM_EN is defined
module rtc_display_core
  import rtc_pkg::*;
#(
  parameter int unsigned DIV      = 100,
  parameter bit          MODE_24H = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic       i_load,
  input  logic [7:0] i_load_hh,
  input  logic [7:0] i_load_mm,
  input  logic [7:0] i_load_ss,
  input  logic       i_load_pm,
  input  logic       i_alarm_set,
  input  logic       i_alarm_clr,
  output logic [6:0] d1,
  output logic [6:0] d2,
  output logic [6:0] d3,
  output logic [6:0] d4,
  output logic [6:0] d5,
  output logic [6:0] d6,
  output logic [1:0] o_dpnt,
  output logic       o_pm_am,
  output logic       o_tick,
  output logic       o_load_err,
  output logic       o_alarm
);

  localparam int unsigned    PW        = $clog2(DIV);
  localparam logic [PW-1:0]  PRESC_MAX = PW'(DIV - 1);
  localparam logic [PW-1:0]  PRESC_HLF = PW'(DIV / 2);
  localparam logic [7:0]     RST_HH    = MODE_24H ? RST_HH_24 : RST_HH_12;

  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    hh_q, hh_d;
  logic [7:0]    mm_q, mm_d;
  logic [7:0]    ss_q, ss_d;
  logic          pm_q, pm_d;
  logic          lerr_q, lerr_d;
  logic          tick;
  logic          load_ok;
  logic          time_upd;
  logic [6:0]    seg_h_t;

  assign tick = i_en && (presc_q == PRESC_MAX);

  // Range check of the load values for the configured hour mode
  always_comb begin
    load_ok = bcd_ok(i_load_hh) && bcd_ok(i_load_mm) && bcd_ok(i_load_ss) &&
              (i_load_mm <= 8'h59) && (i_load_ss <= 8'h59);
    if (MODE_24H) begin
      load_ok = load_ok && (i_load_hh <= 8'h23);
    end else begin
      load_ok = load_ok && (i_load_hh >= 8'h01) && (i_load_hh <= 8'h12);
    end
  end

  // Next-state for prescaler and time: a valid load wins over counting
  always_comb begin
    presc_d  = presc_q;
    hh_d     = hh_q;
    mm_d     = mm_q;
    ss_d     = ss_q;
    pm_d     = pm_q;
    lerr_d   = 1'b0;
    time_upd = 1'b0;
    if (i_load && load_ok) begin
      hh_d     = i_load_hh;
      mm_d     = i_load_mm;
      ss_d     = i_load_ss;
      pm_d     = MODE_24H ? 1'b0 : i_load_pm;
      presc_d  = '0;
      time_upd = 1'b1;
    end else begin
      lerr_d = i_load;
      if (i_en) begin
        presc_d = tick ? '0 : presc_q + PW'(1);
      end
      if (tick) begin
        time_upd = 1'b1;
        if (ss_q == 8'h59) begin
          ss_d = 8'h00;
          if (mm_q == 8'h59) begin
            mm_d = 8'h00;
            if (MODE_24H) begin
              hh_d = (hh_q == 8'h23) ? 8'h00 : bcd_inc(hh_q);
            end else if (hh_q == 8'h12) begin
              hh_d = 8'h01;
            end else begin
              hh_d = bcd_inc(hh_q);
              if (hh_q == 8'h11) begin
                pm_d = ~pm_q;
              end
            end
          end else begin
            mm_d = bcd_inc(mm_q);
          end
        end else begin
          ss_d = bcd_inc(ss_q);
        end
      end
    end
  end

  // Time and prescaler registers with synchronous active-low reset
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      presc_q <= '0;
      hh_q    <= RST_HH;
      mm_q    <= RST_MM;
      ss_q    <= RST_SS;
      pm_q    <= RST_PM;
      lerr_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      hh_q    <= hh_d;
      mm_q    <= mm_d;
      ss_q    <= ss_d;
      pm_q    <= pm_d;
      lerr_q  <= lerr_d;
    end
  end

`ifdef RTC_ALARM_EN
  logic [7:0] al_hh_q, al_hh_d;
  logic [7:0] al_mm_q, al_mm_d;
  logic       al_pm_q, al_pm_d;
  logic       armed_q, armed_d;
  logic       alarm_q, alarm_d;
  logic       al_hit;

  // Alarm capture, match against the freshly computed time, sticky flag
  always_comb begin
    al_hh_d = al_hh_q;
    al_mm_d = al_mm_q;
    al_pm_d = al_pm_q;
    armed_d = armed_q;
    alarm_d = alarm_q;
    al_hit  = armed_q && time_upd && (ss_d == 8'h00) &&
              (hh_d == al_hh_q) && (mm_d == al_mm_q) &&
              (MODE_24H || (pm_d == al_pm_q));
    if (i_alarm_set) begin
      al_hh_d = i_load_hh;
      al_mm_d = i_load_mm;
      al_pm_d = MODE_24H ? 1'b0 : i_load_pm;
      armed_d = 1'b1;
    end
    if (al_hit) begin
      alarm_d = 1'b1;
    end else if (i_alarm_clr) begin
      alarm_d = 1'b0;
    end
  end

  // Alarm registers; reset disarms and zeroes the alarm time
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      al_hh_q <= 8'h00;
      al_mm_q <= 8'h00;
      al_pm_q <= 1'b0;
      armed_q <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      al_hh_q <= al_hh_d;
      al_mm_q <= al_mm_d;
      al_pm_q <= al_pm_d;
      armed_q <= armed_d;
      alarm_q <= alarm_d;
    end
  end

  assign o_alarm = alarm_q;
`else
  logic unused_alarm;
  assign unused_alarm = ^{i_alarm_set, i_alarm_clr, time_upd};
  assign o_alarm      = 1'b0;
`endif

  assign o_tick     = tick;
  assign o_load_err = lerr_q;
  assign o_pm_am    = MODE_24H ? 1'b0 : pm_q;
  assign o_dpnt     = (presc_q < PRESC_HLF) ? 2'b11 : 2'b00;

  seg7_encoder u_seg_s_u (.i_bcd(ss_q[3:0]), .o_seg(d1));
  seg7_encoder u_seg_s_t (.i_bcd(ss_q[7:4]), .o_seg(d2));
  seg7_encoder u_seg_m_u (.i_bcd(mm_q[3:0]), .o_seg(d3));
  seg7_encoder u_seg_m_t (.i_bcd(mm_q[7:4]), .o_seg(d4));
  seg7_encoder u_seg_h_u (.i_bcd(hh_q[3:0]), .o_seg(d5));
  seg7_encoder u_seg_h_t (.i_bcd(hh_q[7:4]), .o_seg(seg_h_t));

  // Leading hour zero is suppressed only on the 12-hour display
  assign d6 = (!MODE_24H && (hh_q[7:4] == 4'd0)) ? SEG_BLANK : seg_h_t;

endmodule

// File: tb/tb_rtc_display_core.sv
// tb/tb_rtc_display_core.sv - scoreboard bench for rtc_display_core, 24h and 12h instances at DIV=4
module tb_rtc_display_core;

`ifdef RTC_ALARM_EN
  localparam logic AL_ON = 1'b1;
`else
  localparam logic AL_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst [2];
  logic       en  [2];
  logic       ld  [2];
  logic       lpm [2];
  logic       aset[2];
  logic       aclr[2];
  logic [7:0] lhh [2];
  logic [7:0] lmm [2];
  logic [7:0] lss [2];
  logic [6:0] s1[2], s2[2], s3[2], s4[2], s5[2], s6[2];
  logic [1:0] dp  [2];
  logic       pmo [2];
  logic       tk  [2];
  logic       lerr[2];
  logic       alm [2];

  rtc_display_core #(.DIV(4), .MODE_24H(1'b1)) u_24 (
    .i_clk(clk), .i_rst(rst[0]), .i_en(en[0]), .i_load(ld[0]),
    .i_load_hh(lhh[0]), .i_load_mm(lmm[0]), .i_load_ss(lss[0]), .i_load_pm(lpm[0]),
    .i_alarm_set(aset[0]), .i_alarm_clr(aclr[0]),
    .d1(s1[0]), .d2(s2[0]), .d3(s3[0]), .d4(s4[0]), .d5(s5[0]), .d6(s6[0]),
    .o_dpnt(dp[0]), .o_pm_am(pmo[0]), .o_tick(tk[0]), .o_load_err(lerr[0]), .o_alarm(alm[0])
  );

  rtc_display_core #(.DIV(4), .MODE_24H(1'b0)) u_12 (
    .i_clk(clk), .i_rst(rst[1]), .i_en(en[1]), .i_load(ld[1]),
    .i_load_hh(lhh[1]), .i_load_mm(lmm[1]), .i_load_ss(lss[1]), .i_load_pm(lpm[1]),
    .i_alarm_set(aset[1]), .i_alarm_clr(aclr[1]),
    .d1(s1[1]), .d2(s2[1]), .d3(s3[1]), .d4(s4[1]), .d5(s5[1]), .d6(s6[1]),
    .o_dpnt(dp[1]), .o_pm_am(pmo[1]), .o_tick(tk[1]), .o_load_err(lerr[1]), .o_alarm(alm[1])
  );

  typedef struct {
    int         sel;
    string      tag;
    logic [7:0] hh;
    logic [7:0] mm;
    logic [7:0] ss;
    logic       pm;
    int         presc;
    logic       tick;
    logic       lerr;
    logic       alm;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [6:0] segt [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                            7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  function automatic logic [41:0] exp_segs(input exp_t e);
    logic [6:0] h_t;
    h_t = (e.sel == 1 && e.hh[7:4] == 4'd0) ? 7'h00 : segt[e.hh[7:4]];
    return {h_t, segt[e.hh[3:0]], segt[e.mm[7:4]], segt[e.mm[3:0]],
            segt[e.ss[7:4]], segt[e.ss[3:0]]};
  endfunction

  // Monitor: every queued expectation is compared at the next falling edge
  exp_t        m_e;
  logic [41:0] m_act_s, m_want_s;
  logic [5:0]  m_act_f, m_want_f;
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      m_e      = sb.pop_front();
      m_act_s  = {s6[m_e.sel], s5[m_e.sel], s4[m_e.sel], s3[m_e.sel], s2[m_e.sel], s1[m_e.sel]};
      m_want_s = exp_segs(m_e);
      n_cmp++;
      if (m_act_s !== m_want_s) begin
        n_bad++;
        $display("FAIL %s segs: got %h want %h (time %0t)", m_e.tag, m_act_s, m_want_s, $time);
      end
      m_act_f  = {pmo[m_e.sel], dp[m_e.sel], tk[m_e.sel], lerr[m_e.sel], alm[m_e.sel]};
      m_want_f = {m_e.pm, (m_e.presc < 2) ? 2'b11 : 2'b00, m_e.tick, m_e.lerr, m_e.alm};
      n_cmp++;
      if (m_act_f !== m_want_f) begin
        n_bad++;
        $display("FAIL %s flags{pm,dpnt,tick,lerr,alarm}: got %b want %b (time %0t)",
                 m_e.tag, m_act_f, m_want_f, $time);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input int sel, input string tag, input logic [7:0] hh, input logic [7:0] mm,
                     input logic [7:0] ss, input logic pm, input int presc, input logic tick,
                     input logic le, input logic al);
    exp_t e;
    e.sel = sel; e.tag = tag; e.hh = hh; e.mm = mm; e.ss = ss; e.pm = pm;
    e.presc = presc; e.tick = tick; e.lerr = le; e.alm = al;
    sb.push_back(e);
  endtask

  task automatic load(input int sel, input logic [7:0] hh, input logic [7:0] mm,
                      input logic [7:0] ss, input logic pm);
    ld[sel] = 1'b1; lhh[sel] = hh; lmm[sel] = mm; lss[sel] = ss; lpm[sel] = pm;
    step();
    ld[sel] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b0; en[i] = 1'b0; ld[i] = 1'b0; lpm[i] = 1'b0;
      aset[i] = 1'b0; aclr[i] = 1'b0; lhh[i] = 8'h00; lmm[i] = 8'h00; lss[i] = 8'h00;
    end
    step();
    step();
    chk(0, "rst24", 8'h00, 8'h00, 8'h00, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    chk(1, "rst12", 8'h12, 8'h00, 8'h00, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    rst[0] = 1'b1; rst[1] = 1'b1; en[0] = 1'b1;

    // 24h rollover 23:59:58 -> 23:59:59 -> 00:00:00
    load(0, 8'h23, 8'h59, 8'h58, 1'b0);
    chk(0, "ld235958", 8'h23, 8'h59, 8'h58, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      step();
      if (i < 4)      chk(0, "roll_a", 8'h23, 8'h59, 8'h58, 1'b0, i % 4, (i % 4) == 3, 1'b0, 1'b0);
      else if (i < 8) chk(0, "roll_b", 8'h23, 8'h59, 8'h59, 1'b0, i % 4, (i % 4) == 3, 1'b0, 1'b0);
      else            chk(0, "roll_c", 8'h00, 8'h00, 8'h00, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    end

    // Rejected loads with counting frozen
    en[0] = 1'b0;
    load(0, 8'h24, 8'h00, 8'h00, 1'b0);
    chk(0, "bad_hh24", 8'h00, 8'h00, 8'h00, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    step();
    chk(0, "err_once", 8'h00, 8'h00, 8'h00, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    load(0, 8'h10, 8'h5A, 8'h00, 1'b0);
    chk(0, "bad_mm5a", 8'h00, 8'h00, 8'h00, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    load(0, 8'h10, 8'h00, 8'h60, 1'b0);
    chk(0, "bad_ss60", 8'h00, 8'h00, 8'h00, 1'b0, 0, 1'b0, 1'b1, 1'b0);
    load(0, 8'h12, 8'h34, 8'h56, 1'b0);
    chk(0, "ld_en0", 8'h12, 8'h34, 8'h56, 1'b0, 0, 1'b0, 1'b0, 1'b0);

    // Freeze mid-second and resume from the same count
    en[0] = 1'b1;
    step();
    step();
    chk(0, "pre_frz", 8'h12, 8'h34, 8'h56, 1'b0, 2, 1'b0, 1'b0, 1'b0);
    en[0] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk(0, "frozen", 8'h12, 8'h34, 8'h56, 1'b0, 2, 1'b0, 1'b0, 1'b0);
    end
    en[0] = 1'b1;
    step();
    chk(0, "resume3", 8'h12, 8'h34, 8'h56, 1'b0, 3, 1'b1, 1'b0, 1'b0);
    step();
    chk(0, "resume0", 8'h12, 8'h34, 8'h57, 1'b0, 0, 1'b0, 1'b0, 1'b0);

    // Load coincident with a tick drops the increment
    step(); step(); step();
    chk(0, "pre_ldtk", 8'h12, 8'h34, 8'h57, 1'b0, 3, 1'b1, 1'b0, 1'b0);
    load(0, 8'h01, 8'h02, 8'h03, 1'b0);
    chk(0, "ld_on_tk", 8'h01, 8'h02, 8'h03, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    step(); step(); step(); step();
    chk(0, "post_ldtk", 8'h01, 8'h02, 8'h04, 1'b0, 0, 1'b0, 1'b0, 1'b0);

    // Alarm at 07:30, fired by the tick out of 07:29:59
    aset[0] = 1'b1; lhh[0] = 8'h07; lmm[0] = 8'h30;
    step();
    aset[0] = 1'b0;
    load(0, 8'h07, 8'h29, 8'h59, 1'b0);
    chk(0, "al_ld", 8'h07, 8'h29, 8'h59, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    step(); step(); step();
    chk(0, "al_pre", 8'h07, 8'h29, 8'h59, 1'b0, 3, 1'b1, 1'b0, 1'b0);
    step();
    chk(0, "al_fire", 8'h07, 8'h30, 8'h00, 1'b0, 0, 1'b0, 1'b0, AL_ON);
    step(); step();
    chk(0, "al_hold", 8'h07, 8'h30, 8'h00, 1'b0, 2, 1'b0, 1'b0, AL_ON);
    aclr[0] = 1'b1;
    step();
    aclr[0] = 1'b0;
    chk(0, "al_clr", 8'h07, 8'h30, 8'h00, 1'b0, 3, 1'b1, 1'b0, 1'b0);

    // Reset mid-second with load and alarm_set asserted
    step(); step(); step();
    chk(0, "pre_rst", 8'h07, 8'h30, 8'h01, 1'b0, 2, 1'b0, 1'b0, 1'b0);
    rst[0] = 1'b0; ld[0] = 1'b1; aset[0] = 1'b1;
    lhh[0] = 8'h05; lmm[0] = 8'h05; lss[0] = 8'h05;
    step();
    chk(0, "rst_mid", 8'h00, 8'h00, 8'h00, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    rst[0] = 1'b1; ld[0] = 1'b0; aset[0] = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      if (i < 4) chk(0, "rst_run", 8'h00, 8'h00, 8'h00, 1'b0, i, i == 3, 1'b0, 1'b0);
      else       chk(0, "rst_1s", 8'h00, 8'h00, 8'h01, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    end

    // 12h: 11:59:59 AM -> 12:00:00 PM
    en[1] = 1'b1;
    load(1, 8'h11, 8'h59, 8'h59, 1'b0);
    chk(1, "ld115959", 8'h11, 8'h59, 8'h59, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      step();
      if (i < 4) chk(1, "am_run", 8'h11, 8'h59, 8'h59, 1'b0, i, i == 3, 1'b0, 1'b0);
      else       chk(1, "to_pm", 8'h12, 8'h00, 8'h00, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    end

    // 12h: 12:59:59 PM -> 01:00:00 PM with blank leading digit
    load(1, 8'h12, 8'h59, 8'h59, 1'b1);
    chk(1, "ld125959", 8'h12, 8'h59, 8'h59, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      step();
      if (i < 4) chk(1, "pm_run", 8'h12, 8'h59, 8'h59, 1'b1, i, i == 3, 1'b0, 1'b0);
      else       chk(1, "to_01pm", 8'h01, 8'h00, 8'h00, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    end

    // 12h rejected hours
    en[1] = 1'b0;
    load(1, 8'h00, 8'h30, 8'h00, 1'b0);
    chk(1, "bad_hh00", 8'h01, 8'h00, 8'h00, 1'b1, 0, 1'b0, 1'b1, 1'b0);
    step();
    chk(1, "err12_once", 8'h01, 8'h00, 8'h00, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    load(1, 8'h13, 8'h00, 8'h00, 1'b1);
    chk(1, "bad_hh13", 8'h01, 8'h00, 8'h00, 1'b1, 0, 1'b0, 1'b1, 1'b0);

    step();
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
